execute_stage_mc: RTL and testbench

- Parametrised, registered execute stage for the MIPS datapath; supersedes the single-cycle combinational execute path.
- Adds a valid/ready handshake on both sides, an EX/MEM output register, and HI/LO registers.
- Adds an iterative multiplier (MULT / MUL) that stalls upstream while it runs.
- Sits between the ID/EX latch and the memory stage.

---
 rtl/execute_stage_mc.sv | 195 +++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_mc.sv
// Registered MIPS execute stage: valid/ready on both sides, EX/MEM output register,
// HI/LO registers and an iterative shift-add multiplier that stalls upstream while it runs.
module execute_stage_mc #(
   parameter int WIDTH    = 32,
   parameter int RA_W     = 5,
   parameter int CONST_B2 = 8,
   parameter int CONST_B3 = 10
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUOp,
   input  logic             ALUSrc0,
   input  logic [1:0]       ALUSrc1,
   input  logic             RegDst,
   input  logic [4:0]       Shamt,
   input  logic [WIDTH-1:0] Reg_Data1,
   input  logic [WIDTH-1:0] Reg_Data2,
   input  logic [WIDTH-1:0] Imm,
   input  logic [WIDTH-1:0] PCPlusFour,
   input  logic [RA_W-1:0]  rt,
   input  logic [RA_W-1:0]  rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic [WIDTH-1:0] PC_Plus_Branch,
   output logic [RA_W-1:0]  WriteReg,
   output logic             busy
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW    = 2 * WIDTH;

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT  = 4'd6,  OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA = 4'd9,  OP_MULT = 4'd10, OP_MUL  = 4'd11;
   localparam logic [3:0] OP_MFHI = 4'd12, OP_MFLO = 4'd13, OP_MTHI = 4'd14, OP_MTLO = 4'd15;

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state_reg, state_next;
   logic               out_valid_reg, out_valid_next;
   logic [WIDTH-1:0]   result_reg, result_next;
   logic               zero_reg, zero_next;
   logic [WIDTH-1:0]   pcb_reg, pcb_next;
   logic [RA_W-1:0]    wreg_reg, wreg_next;
   logic [WIDTH-1:0]   hi_reg, hi_next, lo_reg, lo_next;
   logic [PW-1:0]      mcand_reg, mcand_next, acc_reg, acc_next;
   logic [WIDTH-1:0]   mplier_reg, mplier_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               neg_reg, neg_next, is_mult_reg, is_mult_next;

   logic [WIDTH-1:0]   op_a, op_b, alu_res, mag_a, mag_b;
   logic [PW-1:0]      acc_step, prod_final;
   logic               accept, is_mul_op;

   assign in_ready       = (state_reg == IDLE) && (!out_valid_reg || out_ready);
   assign accept         = in_valid && in_ready;
   assign busy           = (state_reg == MUL);
   assign out_valid      = out_valid_reg;
   assign ALUResult      = result_reg;
   assign Zero           = zero_reg;
   assign PC_Plus_Branch = pcb_reg;
   assign WriteReg       = wreg_reg;

   assign op_a = ALUSrc0 ? WIDTH'(Shamt) : Reg_Data1;
   always_comb begin
      case (ALUSrc1)
         2'd0:    op_b = Reg_Data2;
         2'd1:    op_b = Imm;
         2'd2:    op_b = WIDTH'(CONST_B2);
         default: op_b = WIDTH'(CONST_B3);
      endcase
   end

   always_comb begin
      case (ALUOp)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOR:  alu_res = ~(op_a | op_b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLL:  alu_res = op_b << op_a[4:0];
         OP_SRL:  alu_res = op_b >> op_a[4:0];
         OP_SRA:  alu_res = WIDTH'($signed(op_b) >>> op_a[4:0]);
         OP_MFHI: alu_res = hi_reg;
         OP_MFLO: alu_res = lo_reg;
         OP_MTHI, OP_MTLO: alu_res = op_a;
         default: alu_res = '0;
      endcase
   end

   // Magnitudes stay WIDTH bits unsigned so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
   assign is_mul_op  = (ALUOp == OP_MULT) || (ALUOp == OP_MUL);
   assign mag_a      = op_a[WIDTH-1] ? -op_a : op_a;
   assign mag_b      = op_b[WIDTH-1] ? -op_b : op_b;
   assign acc_step   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign prod_final = neg_reg ? -acc_step : acc_step;

   always_comb begin
      state_next     = state_reg;
      out_valid_next = out_valid_reg;
      result_next    = result_reg;
      zero_next      = zero_reg;
      pcb_next       = pcb_reg;
      wreg_next      = wreg_reg;
      hi_next        = hi_reg;
      lo_next        = lo_reg;
      mcand_next     = mcand_reg;
      mplier_next    = mplier_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      neg_next       = neg_reg;
      is_mult_next   = is_mult_reg;
      if (out_valid_reg && out_ready)
         out_valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               pcb_next  = PCPlusFour + (Imm << 2);
               wreg_next = RegDst ? rd : rt;
               if (is_mul_op) begin
                  state_next   = MUL;
                  mcand_next   = {{WIDTH{1'b0}}, mag_a};
                  mplier_next  = mag_b;
                  acc_next     = '0;
                  cnt_next     = '0;
                  neg_next     = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                  is_mult_next = (ALUOp == OP_MULT);
               end else begin
                  result_next    = alu_res;
                  zero_next      = (alu_res == '0);
                  out_valid_next = 1'b1;
                  if (ALUOp == OP_MTHI) hi_next = op_a;
                  if (ALUOp == OP_MTLO) lo_next = op_a;
               end
            end
         end
         MUL: begin
            acc_next    = acc_step;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(WIDTH-1)) begin
               state_next     = IDLE;
               result_next    = prod_final[WIDTH-1:0];
               zero_next      = (prod_final[WIDTH-1:0] == '0);
               out_valid_next = 1'b1;
               if (is_mult_reg) begin
                  hi_next = prod_final[PW-1:WIDTH];
                  lo_next = prod_final[WIDTH-1:0];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg     <= IDLE;
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         zero_reg      <= 1'b1;
         pcb_reg       <= '0;
         wreg_reg      <= '0;
         hi_reg        <= '0;
         lo_reg        <= '0;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         neg_reg       <= 1'b0;
         is_mult_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= out_valid_next;
         result_reg    <= result_next;
         zero_reg      <= zero_next;
         pcb_reg       <= pcb_next;
         wreg_reg      <= wreg_next;
         hi_reg        <= hi_next;
         lo_reg        <= lo_next;
         mcand_reg     <= mcand_next;
         mplier_reg    <= mplier_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         neg_reg       <= neg_next;
         is_mult_reg   <= is_mult_next;
      end
   end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Scoreboard bench for execute_stage_mc: a stimulus process pushes model results,
// a monitor pops and compares them whenever the stage hands a result downstream.
module tb_execute_stage_mc;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, in_ready, out_valid, out_ready, busy, zero, src0, regdst;
   logic [3:0]   op;
   logic [1:0]   src1;
   logic [4:0]   shamt, rt, rd, wreg;
   logic [W-1:0] rd1, rd2, imm, pc4, res, pcb;

   execute_stage_mc #(.WIDTH(W)) dut (
      .Clk(clk), .Reset(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUOp(op),
      .ALUSrc0(src0), .ALUSrc1(src1), .RegDst(regdst), .Shamt(shamt),
      .Reg_Data1(rd1), .Reg_Data2(rd2), .Imm(imm), .PCPlusFour(pc4), .rt(rt), .rd(rd),
      .out_valid(out_valid), .out_ready(out_ready), .ALUResult(res), .Zero(zero),
      .PC_Plus_Branch(pcb), .WriteReg(wreg), .busy(busy));

   // Narrow instance for the 16-bit multiply corner case.
   logic        s_in_valid, s_in_ready, s_out_valid, s_zero, s_busy;
   logic [3:0]  s_op;
   logic [4:0]  s_wreg;
   logic [15:0] s_rd1, s_rd2, s_res, s_pcb;

   execute_stage_mc #(.WIDTH(16)) dut16 (
      .Clk(clk), .Reset(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .ALUOp(s_op),
      .ALUSrc0(1'b0), .ALUSrc1(2'd0), .RegDst(1'b0), .Shamt(5'd0),
      .Reg_Data1(s_rd1), .Reg_Data2(s_rd2), .Imm(16'd0), .PCPlusFour(16'd0),
      .rt(5'd0), .rd(5'd0), .out_valid(s_out_valid), .out_ready(1'b1), .ALUResult(s_res),
      .Zero(s_zero), .PC_Plus_Branch(s_pcb), .WriteReg(s_wreg), .busy(s_busy));

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic [W-1:0] pcb;
      logic [4:0]   wr;
      int           due;
      string        name;
   } exp_t;

   exp_t         sb[$];
   int           n_pass = 0, n_total = 0;
   int           cyc = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   bit           bp_rand = 1'b0, bp_val = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      else n_pass++;
   endtask

   // Downstream backpressure, applied shortly after each rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : bp_val;
      end
   end

   // Monitor: latency on first presentation, field compare on consume.
   bit seen = 1'b0;
   always @(negedge clk) begin
      if (rst) seen = 1'b0;
      else if (out_valid) begin
         if (sb.size() == 0) begin
            if (!seen) chk("unexpected_result", 64'(out_valid), 64'd0);
            seen = 1'b1;
         end else begin
            if (!seen) chk({sb[0].name, "_latency"}, 64'(cyc), 64'(sb[0].due));
            seen = 1'b1;
            if (out_ready) begin
               chk({sb[0].name, "_result"}, 64'(res), 64'(sb[0].res));
               chk({sb[0].name, "_zero"}, 64'(zero), 64'(sb[0].z));
               chk({sb[0].name, "_pcb"}, 64'(pcb), 64'(sb[0].pcb));
               chk({sb[0].name, "_wreg"}, 64'(wreg), 64'(sb[0].wr));
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // Present one operation, wait for acceptance, update the model and push the expectation.
   task automatic issue(input logic [3:0] o, input logic s0, input logic [1:0] s1,
                        input logic rdst, input logic [4:0] sh, input logic [W-1:0] a1,
                        input logic [W-1:0] a2, input logic [W-1:0] im, input logic [W-1:0] pc,
                        input logic [4:0] t, input logic [4:0] d, output int waited);
      logic [W-1:0] a, b, r;
      longint       p;
      exp_t         e;
      op = o; src0 = s0; src1 = s1; regdst = rdst; shamt = sh;
      rd1 = a1; rd2 = a2; imm = im; pc4 = pc; rt = t; rd = d;
      in_valid = 1'b1;
      waited = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
      end else begin
         a = s0 ? W'(sh) : a1;
         case (s1)
            2'd0: b = a2;
            2'd1: b = im;
            2'd2: b = 32'd8;
            default: b = 32'd10;
         endcase
         p = longint'($signed(a)) * longint'($signed(b));
         case (o)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  r = b << a[4:0];
            4'd8:  r = b >> a[4:0];
            4'd9:  r = $unsigned($signed(b) >>> a[4:0]);
            4'd10: begin r = p[31:0]; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd11: r = p[31:0];
            4'd12: r = m_hi;
            4'd13: r = m_lo;
            4'd14: begin r = a; m_hi = a; end
            default: begin r = a; m_lo = a; end
         endcase
         e.res = r; e.z = (r == 0); e.pcb = pc + (im << 2); e.wr = rdst ? d : t;
         e.due = cyc + ((o == 4'd10 || o == 4'd11) ? W + 1 : 1);
         e.name = $sformatf("op%0d", o);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_val();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int w, n;
      rst = 1'b1; in_valid = 1'b0; op = '0; src0 = 1'b0; src1 = '0; regdst = 1'b0;
      shamt = '0; rd1 = '0; rd2 = '0; imm = '0; pc4 = '0; rt = '0; rd = '0;
      s_in_valid = 1'b0; s_op = '0; s_rd1 = '0; s_rd2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", 64'(res), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      chk("rst_pcb", 64'(pcb), 64'd0);
      chk("rst_wreg", 64'(wreg), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ADD with immediate, SUB to zero with branch target
      issue(4'd0, 1'b0, 2'd1, 1'b1, 5'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd3, 5'd9, w);
      issue(4'd1, 1'b0, 2'd0, 1'b0, 5'd0, 32'd7, 32'd7, 32'd3, 32'h100, 5'd4, 5'd9, w);

      // MULT -3 x 0x40000000, busy duration, then MFHI / MFLO
      issue(4'd10, 1'b0, 2'd0, 1'b0, 5'd0, -32'sd3, 32'h4000_0000, 32'd0, 32'd0, 5'd1, 5'd2, w);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk("mult_busy_cycles", 64'(n), 64'd32);
      @(posedge clk);
      #1;
      issue(4'd12, 1'b0, 2'd0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, w);
      issue(4'd13, 1'b0, 2'd0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd6, w);

      // SRA 0x80000000 by 4 under three cycles of backpressure
      issue(4'd9, 1'b1, 2'd0, 1'b0, 5'd4, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 5'd7, 5'd0, w);
      bp_val = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_result", 64'(res), 64'hF800_0000);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      bp_val = 1'b1;
      issue(4'd3, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0F0, 32'h00F, 32'd0, 32'd0, 5'd8, 5'd0, w);
      chk("bp_accept_wait", 64'(w), 64'd0);

      // Randomized mix under random backpressure
      bp_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom), rnd_val(), rnd_val(), rnd_val(),
               rnd_val(), 5'($urandom), 5'($urandom), w);
      end
      bp_rand = 1'b0;

      // Reset in the middle of a MULT after loading non-zero HI/LO
      issue(4'd14, 1'b0, 2'd0, 1'b0, 5'd0, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, w);
      issue(4'd15, 1'b0, 2'd0, 1'b0, 5'd0, 32'h5678, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, w);
      issue(4'd10, 1'b0, 2'd0, 1'b0, 5'd0, 32'd77, 32'd99, 32'd0, 32'd0, 5'd0, 5'd0, w);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      issue(4'd12, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, w);
      issue(4'd13, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, w);

      // 16-bit build: MUL 0x8000 x 0x8000
      s_op = 4'd11; s_rd1 = 16'h8000; s_rd2 = 16'h8000; s_in_valid = 1'b1;
      @(negedge clk);
      chk("w16_in_ready", 64'(s_in_ready), 64'd1);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         n++;
         if (s_out_valid) break;
      end
      chk("w16_latency", 64'(n), 64'd17);
      chk("w16_result", 64'(s_res), 64'h0);
      chk("w16_zero", 64'(s_zero), 64'd1);

      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
